// File: rtl/inst_mem_fetch_port.sv
// Byte-addressed instruction memory with a one-deep registered fetch output (valid/ready),
// flush, a word-wide program-load port, alignment/range fault flags and a fetch counter.
module inst_mem_fetch_port #(
  parameter int unsigned DEPTH_BYTES    = 256,
  parameter int unsigned ALLOW_MISALIGN = 0,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_req_i,
  input  logic [63:0] fetch_addr_i,
  output logic        fetch_ready_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] instruction_o,
  output logic [63:0] inst_addr_o,
  output logic        fault_misalign_o,
  output logic        fault_oob_o,
  input  logic        flush_i,
  input  logic        prog_we_i,
  input  logic [63:0] prog_addr_i,
  input  logic [31:0] prog_data_i,
  output logic [31:0] fetch_count_o
);

  localparam int unsigned AddrW        = $clog2(DEPTH_BYTES);
  localparam logic [63:0] LastWordAddr = 64'(DEPTH_BYTES - 4);
  localparam logic [63:0] DepthBytes   = 64'(DEPTH_BYTES);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [31:0]      instruction_q, instruction_d;
  logic [63:0]      inst_addr_q, inst_addr_d;
  logic             fault_misalign_q, fault_misalign_d;
  logic             fault_oob_q, fault_oob_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  logic [7:0]       mem_q [DEPTH_BYTES];

  logic             accept;
  logic             rd_misalign;
  logic             rd_oob;
  logic [AddrW-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             wr_in_range;
  logic [AddrW-1:0] wr_idx;

  assign fetch_ready_o = !prog_we_i && !flush_i && ((state_q == StEmpty) || inst_ready_i);
  assign accept        = fetch_req_i && fetch_ready_o;

  // Range check on the full 64-bit address so a+3 can never wrap back into range.
  assign rd_misalign = (ALLOW_MISALIGN == 0) && (fetch_addr_i[1:0] != 2'b00);
  assign rd_oob      = fetch_addr_i > LastWordAddr;
  assign rd_idx      = fetch_addr_i[AddrW-1:0];
  assign rd_word     = {mem_q[rd_idx + AddrW'(3)], mem_q[rd_idx + AddrW'(2)],
                        mem_q[rd_idx + AddrW'(1)], mem_q[rd_idx]};

  // DEPTH_BYTES is a multiple of 4, so the byte address range check covers the whole word.
  assign wr_in_range = prog_addr_i < DepthBytes;
  assign wr_idx      = {prog_addr_i[AddrW-1:2], 2'b00};

  always_comb begin
    state_d          = state_q;
    instruction_d    = instruction_q;
    inst_addr_d      = inst_addr_q;
    fault_misalign_d = fault_misalign_q;
    fault_oob_d      = fault_oob_q;
    fetch_count_d    = fetch_count_q;

    if (accept) begin
      instruction_d    = (rd_misalign || rd_oob) ? NOP_WORD : rd_word;
      inst_addr_d      = fetch_addr_i;
      fault_misalign_d = rd_misalign;
      fault_oob_d      = rd_oob;
      fetch_count_d    = fetch_count_q + 32'd1;
    end

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (flush_i || (inst_ready_i && !accept)) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= StEmpty;
      instruction_q    <= '0;
      inst_addr_q      <= '0;
      fault_misalign_q <= 1'b0;
      fault_oob_q      <= 1'b0;
      fetch_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      instruction_q    <= instruction_d;
      inst_addr_q      <= inst_addr_d;
      fault_misalign_q <= fault_misalign_d;
      fault_oob_q      <= fault_oob_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  // Memory contents survive reset; only the load port is blocked while reset is high.
  always_ff @(posedge clk_i) begin
    if (!reset_i && prog_we_i && wr_in_range) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[wr_idx + AddrW'(k)] <= prog_data_i[8*k +: 8];
      end
    end
  end

  assign inst_valid_o     = (state_q == StFull);
  assign instruction_o    = instruction_q;
  assign inst_addr_o      = inst_addr_q;
  assign fault_misalign_o = fault_misalign_q;
  assign fault_oob_o      = fault_oob_q;
  assign fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_inst_mem_fetch_port.sv
// Scoreboard bench for inst_mem_fetch_port: one strict-alignment instance and one
// misalign-tolerant instance share all inputs; expected words come from a byte-array model.
module tb_inst_mem_fetch_port;

  localparam int unsigned Depth = 256;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr_a;
    logic        mis_a;
    logic        oob_a;
    logic [31:0] instr_b;
    logic        oob_b;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        inst_ready;
  logic        flush;
  logic        prog_we;
  logic [63:0] prog_addr;
  logic [31:0] prog_data;

  logic        ready_a, valid_a, mis_a, oob_a;
  logic [31:0] instr_a, count_a;
  logic [63:0] iaddr_a;
  logic        ready_b, valid_b, mis_b, oob_b;
  logic [31:0] instr_b, count_b;
  logic [63:0] iaddr_b;

  inst_mem_fetch_port #(
    .DEPTH_BYTES   (Depth),
    .ALLOW_MISALIGN(0),
    .NOP_WORD      (Nop)
  ) dut_a (
    .clk_i           (clk),
    .reset_i         (reset),
    .fetch_req_i     (fetch_req),
    .fetch_addr_i    (fetch_addr),
    .fetch_ready_o   (ready_a),
    .inst_valid_o    (valid_a),
    .inst_ready_i    (inst_ready),
    .instruction_o   (instr_a),
    .inst_addr_o     (iaddr_a),
    .fault_misalign_o(mis_a),
    .fault_oob_o     (oob_a),
    .flush_i         (flush),
    .prog_we_i       (prog_we),
    .prog_addr_i     (prog_addr),
    .prog_data_i     (prog_data),
    .fetch_count_o   (count_a)
  );

  inst_mem_fetch_port #(
    .DEPTH_BYTES   (Depth),
    .ALLOW_MISALIGN(1),
    .NOP_WORD      (Nop)
  ) dut_b (
    .clk_i           (clk),
    .reset_i         (reset),
    .fetch_req_i     (fetch_req),
    .fetch_addr_i    (fetch_addr),
    .fetch_ready_o   (ready_b),
    .inst_valid_o    (valid_b),
    .inst_ready_i    (inst_ready),
    .instruction_o   (instr_b),
    .inst_addr_o     (iaddr_b),
    .fault_misalign_o(mis_b),
    .fault_oob_o     (oob_b),
    .flush_i         (flush),
    .prog_we_i       (prog_we),
    .prog_addr_i     (prog_addr),
    .prog_data_i     (prog_data),
    .fetch_count_o   (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  m_mem [Depth];
  logic        m_valid;
  logic [31:0] m_count;
  exp_t        m_out;
  exp_t        sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input int i);
    return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
  endfunction

  function automatic exp_t model_fetch(input logic [63:0] a);
    exp_t e;
    int   i;
    i         = int'(a[7:0]);
    e.addr    = a;
    e.mis_a   = (a[1:0] != 2'b00);
    e.oob_a   = (a > 64'(Depth - 4));
    e.oob_b   = e.oob_a;
    e.instr_a = Nop;
    e.instr_b = Nop;
    if (!e.oob_a) begin
      e.instr_b = mem_word(i);
      if (!e.mis_a) e.instr_a = mem_word(i);
    end
    return e;
  endfunction

  // One clock: check the combinational handshake, advance the model, check registered outputs.
  task automatic cycle();
    logic exp_ready, acc, take;
    #1;
    exp_ready = !prog_we && !flush && (!m_valid || inst_ready);
    check_eq("fetch_ready_a", 64'(ready_a), 64'(exp_ready));
    check_eq("fetch_ready_b", 64'(ready_b), 64'(exp_ready));
    acc  = fetch_req && exp_ready;
    take = m_valid && inst_ready;
    if (acc && !reset) sb.push_back(model_fetch(fetch_addr));
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_count = '0;
      sb.delete();
    end else begin
      if (prog_we && (prog_addr < 64'(Depth))) begin
        for (int k = 0; k < 4; k++) m_mem[int'({prog_addr[7:2], 2'b00}) + k] = prog_data[8*k +: 8];
      end
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_out   = sb.pop_front();
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end else if (take) begin
        m_valid = 1'b0;
      end
    end
    check_eq("inst_valid_a", 64'(valid_a), 64'(m_valid));
    check_eq("inst_valid_b", 64'(valid_b), 64'(m_valid));
    check_eq("fetch_count_a", 64'(count_a), 64'(m_count));
    check_eq("fetch_count_b", 64'(count_b), 64'(m_count));
    check_eq("instruction_a", 64'(instr_a), 64'(m_out.instr_a));
    check_eq("inst_addr_a", iaddr_a, m_out.addr);
    check_eq("fault_misalign_a", 64'(mis_a), 64'(m_out.mis_a));
    check_eq("fault_oob_a", 64'(oob_a), 64'(m_out.oob_a));
    check_eq("instruction_b", 64'(instr_b), 64'(m_out.instr_b));
    check_eq("inst_addr_b", iaddr_b, m_out.addr);
    check_eq("fault_misalign_b", 64'(mis_b), 64'd0);
    check_eq("fault_oob_b", 64'(oob_b), 64'(m_out.oob_b));
  endtask

  task automatic prog(input logic [63:0] a, input logic [31:0] d);
    fetch_req = 1'b0;
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cycle();
    prog_we   = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a, input logic rdy);
    fetch_req  = 1'b1;
    fetch_addr = a;
    inst_ready = rdy;
    cycle();
    fetch_req  = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    fetch_req  = 1'b0;
    inst_ready = rdy;
    cycle();
  endtask

  logic [31:0] prog_tbl [8];

  initial begin
    prog_tbl = '{32'h0060_0593, 32'h0060_0E93, 32'h1234_5678, 32'hDEAD_BEEF,
                 32'h0F0F_1234, 32'h00A0_0113, 32'h55AA_33CC, 32'h8000_0073};
    for (int i = 0; i < int'(Depth); i++) m_mem[i] = 8'h00;
    m_valid    = 1'b0;
    m_count    = '0;
    m_out      = '0;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    inst_ready = 1'b0;
    flush      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;

    idle(1'b0);
    idle(1'b0);
    reset = 1'b0;
    idle(1'b0);

    for (int i = 0; i < 8; i++) prog(64'(4 * i), prog_tbl[i]);
    prog(64'd252, 32'hAABB_CCDD);
    prog(64'd256, 32'hFFFF_FFFF);

    // Back-to-back fetches.
    fetch(64'd0, 1'b1);
    fetch(64'd4, 1'b1);
    idle(1'b1);

    // Back-pressure: held word, request stalled for three cycles, then released.
    fetch(64'd8, 1'b1);
    for (int i = 0; i < 3; i++) fetch(64'd12, 1'b0);
    fetch(64'd12, 1'b1);
    idle(1'b1);

    fetch(64'd2, 1'b1);
    idle(1'b1);

    fetch(64'(Depth - 2), 1'b1);
    fetch(64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    fetch(64'd252, 1'b1);
    fetch(64'd253, 1'b1);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    idle(1'b1);

    // Flush while FULL with a pending request, then flush coinciding with a program write.
    fetch(64'd20, 1'b0);
    flush = 1'b1;
    fetch(64'd24, 1'b0);
    flush = 1'b0;
    idle(1'b1);
    fetch(64'd24, 1'b0);
    flush     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 64'd29;
    prog_data = 32'h1122_3344;
    fetch(64'd28, 1'b0);
    flush   = 1'b0;
    prog_we = 1'b0;
    fetch(64'd28, 1'b1);
    idle(1'b1);

    // Program write blocks a same-cycle fetch; later write must not alter a held word.
    prog_we   = 1'b1;
    prog_addr = 64'd16;
    prog_data = 32'hCAFE_F00D;
    fetch(64'd16, 1'b1);
    prog_we   = 1'b0;
    fetch(64'd16, 1'b0);
    prog_we   = 1'b1;
    prog_data = 32'h0BAD_C0DE;
    idle(1'b0);
    prog_we   = 1'b0;
    idle(1'b0);
    idle(1'b1);
    fetch(64'd16, 1'b1);
    idle(1'b1);

    // Counter wrap.
    force dut_a.fetch_count_q = 32'hFFFF_FFFF;
    force dut_b.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.fetch_count_q;
    release dut_b.fetch_count_q;
    m_count = 32'hFFFF_FFFF;
    fetch(64'd0, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 40; i++) begin
      fetch_req  = ($urandom_range(0, 1) == 1);
      fetch_addr = 64'($urandom_range(0, 28));
      inst_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      cycle();
    end
    flush     = 1'b0;
    fetch_req = 1'b0;

    // Reset while FULL.
    fetch(64'd4, 1'b0);
    reset      = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 64'd8;
    cycle();
    reset = 1'b0;
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
